// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
package pipe_pkg;

    // Occupancy counter width (0, 1 or 2 entries)
    localparam int unsigned OCC_W = 2;

    // RISC-V canonical NOP (addi x0, x0, 0) used as the IF/ID flush payload
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Stage occupancy state
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// Reusable valid/ready pipeline stage register with a one-entry skid buffer.
// All handshake outputs are decoded from next-state and registered, so there
// is no combinational path from dn_ready_i to up_ready_o or up_valid_i to dn_valid_o.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter logic [DATA_W-1:0] NOP_DATA   = '0,
    parameter bit                FLUSH_NOP  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [OCC_W-1:0]  occ_o
);

    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_dn_valid;
    logic              w_dn_valid_nxt;
    logic              r_up_ready;
    logic              w_up_ready_nxt;
    logic [OCC_W-1:0]  r_occ;
    logic [OCC_W-1:0]  w_occ_nxt;
    logic              w_up_xfer;
    logic              w_dn_xfer;

    assign w_up_xfer = up_valid_i & r_up_ready;
    assign w_dn_xfer = r_dn_valid & dn_ready_i;

    // Next-state, storage and registered-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;

        if (flush_i) begin
            // Skid is invalidated by leaving TWO; any beat accepted this cycle is dropped
            w_main_nxt  = NOP_DATA;
            w_state_nxt = FLUSH_NOP ? ST_ONE : ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_up_xfer) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = up_data_i;
                    end
                end
                ST_ONE: begin
                    if (w_up_xfer && w_dn_xfer) begin
                        w_main_nxt = up_data_i;
                    end else if (w_up_xfer) begin
                        w_state_nxt = ST_TWO;
                        w_skid_nxt  = up_data_i;
                    end else if (w_dn_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_dn_xfer) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end

        w_dn_valid_nxt = (w_state_nxt != ST_EMPTY);
        w_up_ready_nxt = (w_state_nxt != ST_TWO);
        case (w_state_nxt)
            ST_ONE:  w_occ_nxt = OCC_W'(1);
            ST_TWO:  w_occ_nxt = OCC_W'(2);
            default: w_occ_nxt = OCC_W'(0);
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_main     <= RESET_DATA;
            r_skid     <= '0;
            r_dn_valid <= 1'b0;
            r_up_ready <= 1'b1;
            r_occ      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_dn_valid <= w_dn_valid_nxt;
            r_up_ready <= w_up_ready_nxt;
            r_occ      <= w_occ_nxt;
        end
    end

    assign up_ready_o = r_up_ready;
    assign dn_valid_o = r_dn_valid;
    assign dn_data_o  = r_main;
    assign occ_o      = r_occ;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two 32-bit instances sharing stimulus, one with
// FLUSH_NOP=1 (index 1) and one with FLUSH_NOP=0 (index 0), checked against
// a queue-based model, a directed vector table and hand-written sequences.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DW   = 32;
    localparam logic [DW-1:0] RST0 = 32'h5A5A_0000;
    localparam logic [DW-1:0] RST1 = 32'hCAFE_0001;
    localparam logic [DW-1:0] NOP0 = 32'h0000_0BAD;
    localparam logic [DW-1:0] NOP1 = RV_NOP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          up_valid = 1'b0;
    logic [DW-1:0] up_data = '0;
    logic          dn_ready = 1'b0;

    logic          up_ready0, up_ready1, dn_valid0, dn_valid1;
    logic [DW-1:0] dn_data0, dn_data1;
    logic [1:0]    occ0, occ1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-instance FIFO of held beats plus last presented payload
    logic [31:0] mq [2][$];
    logic [31:0] mlast [2];

    typedef struct {
        logic        f;
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  eo;
        logic        eu;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .RESET_DATA(RST0), .NOP_DATA(NOP0), .FLUSH_NOP(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .up_valid_i(up_valid), .up_ready_o(up_ready0), .up_data_i(up_data),
        .dn_valid_o(dn_valid0), .dn_ready_i(dn_ready), .dn_data_o(dn_data0), .occ_o(occ0)
    );

    pipe_stage_reg #(.DATA_W(DW), .RESET_DATA(RST1), .NOP_DATA(NOP1), .FLUSH_NOP(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .up_valid_i(up_valid), .up_ready_o(up_ready1), .up_data_i(up_data),
        .dn_valid_o(dn_valid1), .dn_ready_i(dn_ready), .dn_data_o(dn_data1), .occ_o(occ1)
    );

    function automatic logic act_valid(input int k);
        return (k == 1) ? dn_valid1 : dn_valid0;
    endfunction
    function automatic logic [31:0] act_data(input int k);
        return (k == 1) ? dn_data1 : dn_data0;
    endfunction
    function automatic logic [31:0] act_occ(input int k);
        return (k == 1) ? 32'(occ1) : 32'(occ0);
    endfunction
    function automatic logic act_ready(input int k);
        return (k == 1) ? up_ready1 : up_ready0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mlast[k] = (k == 1) ? RST1 : RST0;
        end
    endtask

    // Apply one clock edge's worth of handshake rules to the model
    task automatic model_step(input logic f, input logic v, input logic [31:0] d, input logic r);
        for (int k = 0; k < 2; k++) begin
            bit uxf;
            bit dxf;
            uxf = v && (mq[k].size() < 2);
            dxf = r && (mq[k].size() > 0);
            if (f) begin
                mq[k].delete();
                if (k == 1) mq[k].push_back(NOP1);
                else        mlast[k] = NOP0;
            end else begin
                if (dxf) mlast[k] = mq[k].pop_front();
                if (uxf) mq[k].push_back(d);
            end
        end
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < 2; k++) begin
            int sz;
            sz = mq[k].size();
            chk($sformatf("%s.u%0d.dn_valid", tag, k), 32'(act_valid(k)), 32'(sz != 0));
            chk($sformatf("%s.u%0d.dn_data", tag, k), act_data(k), (sz != 0) ? mq[k][0] : mlast[k]);
            chk($sformatf("%s.u%0d.occ", tag, k), act_occ(k), 32'(sz));
            chk($sformatf("%s.u%0d.up_ready", tag, k), 32'(act_ready(k)), 32'(sz < 2));
        end
    endtask

    // Drive inputs just after a falling edge, clock once, return at the next falling edge
    task automatic cycle(input logic f, input logic v, input logic [31:0] d, input logic r);
        flush = f; up_valid = v; up_data = d; dn_ready = r;
        @(posedge clk);
        model_step(f, v, d, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
        #1;
        chk("rst.u1.dn_valid", 32'(dn_valid1), 32'd0);
        chk("rst.u1.dn_data", dn_data1, RST1);
        chk("rst.u1.up_ready", 32'(up_ready1), 32'd1);
        chk("rst.u1.occ", 32'(occ1), 32'd0);
        chk("rst.u0.dn_data", dn_data0, RST0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_model("post_rst");
    endtask

    initial begin
        model_reset();
        do_reset();

        // Vector table: streaming 1..8, drain, then backpressure with release
        for (int i = 1; i <= 8; i++) tbl.push_back('{1'b0, 1'b1, 32'(i), 1'b1, 1'b1, 32'(i), 2'd1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd8, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'd1, 1'b1, 1'b1, 32'd1, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'd2, 1'b1, 1'b1, 32'd2, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'd3, 1'b1, 1'b1, 32'd3, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'd4, 1'b0, 1'b1, 32'd3, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'd5, 1'b0, 1'b1, 32'd3, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'd5, 1'b0, 1'b1, 32'd3, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'd5, 1'b1, 1'b1, 32'd4, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'd5, 1'b1, 1'b1, 32'd5, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 2'd0, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d.dn_valid", i), 32'(dn_valid1), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d.dn_data", i), dn_data1, tbl[i].ed);
            chk($sformatf("tbl%0d.occ", i), 32'(occ1), 32'(tbl[i].eo));
            chk($sformatf("tbl%0d.up_ready", i), 32'(up_ready1), 32'(tbl[i].eu));
            check_model($sformatf("tbl%0d", i));
        end

        // Flush while holding two beats
        do_reset();
        cycle(1'b0, 1'b1, 32'h11, 1'b0);
        cycle(1'b0, 1'b1, 32'h22, 1'b0);
        chk("ftwo.pre.occ", 32'(occ1), 32'd2);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("ftwo.u1.dn_valid", 32'(dn_valid1), 32'd1);
        chk("ftwo.u1.dn_data", dn_data1, 32'h0000_0013);
        chk("ftwo.u1.occ", 32'(occ1), 32'd1);
        chk("ftwo.u1.up_ready", 32'(up_ready1), 32'd1);
        chk("ftwo.u0.dn_valid", 32'(dn_valid0), 32'd0);
        chk("ftwo.u0.dn_data", dn_data0, NOP0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("ftwo.drain.u1.dn_valid", 32'(dn_valid1), 32'd0);
        chk("ftwo.drain.u1.dn_data", dn_data1, 32'h0000_0013);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("ftwo.idle.u1.dn_valid", 32'(dn_valid1), 32'd0);
        check_model("ftwo");

        // Flush concurrent with an accepted beat
        do_reset();
        cycle(1'b1, 1'b1, 32'hA5, 1'b1);
        chk("fxfer.u0.occ", 32'(occ0), 32'd0);
        chk("fxfer.u0.dn_valid", 32'(dn_valid0), 32'd0);
        chk("fxfer.u0.dn_data", dn_data0, NOP0);
        chk("fxfer.u1.dn_data", dn_data1, NOP1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("fxfer.after.u0.dn_valid", 32'(dn_valid0), 32'd0);
        chk("fxfer.after.u0.dn_data", dn_data0, NOP0);
        chk("fxfer.after.u1.dn_valid", 32'(dn_valid1), 32'd0);
        check_model("fxfer");

        // Asynchronous reset while full
        do_reset();
        cycle(1'b0, 1'b1, 32'h7, 1'b0);
        cycle(1'b0, 1'b1, 32'h8, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.u1.dn_valid", 32'(dn_valid1), 32'd0);
        chk("arst.u1.dn_data", dn_data1, RST1);
        chk("arst.u1.occ", 32'(occ1), 32'd0);
        chk("arst.u1.up_ready", 32'(up_ready1), 32'd1);
        do_reset();

        // Randomised valid/ready/flush against the model
        for (int c = 0; c < 10000; c++) begin
            logic f, v, r;
            logic [31:0] d;
            logic        pv [2];
            logic [31:0] pd [2];
            f = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            d = $urandom;
            for (int k = 0; k < 2; k++) begin
                pv[k] = act_valid(k);
                pd[k] = act_data(k);
            end
            cycle(f, v, d, r);
            check_model($sformatf("rnd%0d", c));
            if (!f && !r) begin
                for (int k = 0; k < 2; k++) begin
                    if (pv[k]) begin
                        chk($sformatf("stable%0d.u%0d.valid", c, k), 32'(act_valid(k)), 32'd1);
                        chk($sformatf("stable%0d.u%0d.data", c, k), act_data(k), pd[k]);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It replaces the fixed-width, stall-driven inter-stage registers (IF/ID and successors) with one reusable block. Data width, flush-injected payload and reset payload are configurable. A flush can either drop the stage contents or replace them with a valid NOP beat. Full throughput is sustained with no combinational path from downstream ready to upstream ready.

## Interface
- DATA_W, 64, payload width in bits (≥1)
- RESET_DATA, {DATA_W{1'b0}}, value of dn_data_o while reset is asserted
- NOP_DATA, {DATA_W{1'b0}}, payload injected by flush when FLUSH_NOP=1; also the idle value of dn_data_o after a flush
- FLUSH_NOP, 1, 1: flush leaves one valid NOP_DATA beat in the stage; 0: flush leaves the stage empty

- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush; highest priority after reset
- up_valid_i  in  1  upstream beat valid
- up_ready_o  out  1  stage can accept a beat (registered)
- up_data_i  in  DATA_W  upstream payload
- dn_valid_o  out  1  downstream beat valid (registered)
- dn_ready_i  in  1  downstream accepts the beat
- dn_data_o  out  DATA_W  downstream payload (registered)
- occ_o  out  2  entries held: 0, 1 or 2

## Operation
- Storage: main register (drives dn_*) and skid register. Transfers: up_xfer = up_valid_i & up_ready_o; dn_xfer = dn_valid_o & dn_ready_i.
- States: EMPTY (occ 0), ONE (main valid), TWO (main and skid valid).
- EMPTY: up_xfer -> ONE, main <= up_data_i.
- ONE: up_xfer & dn_xfer -> ONE, main <= up_data_i. up_xfer only -> TWO, skid <= up_data_i. dn_xfer only -> EMPTY. Neither: hold.
- TWO: dn_xfer -> ONE, main <= skid. Otherwise hold. up_ready_o=0, so up_xfer cannot occur.
- up_ready_o = (state != TWO). It is a registered value.
- flush_i (any state): skid is invalidated.
  - FLUSH_NOP=1: next state ONE, main <= NOP_DATA.
  - FLUSH_NOP=0: next state EMPTY, dn_data_o <= NOP_DATA.
  - A beat handshaked (up_xfer) in the flush cycle counts as accepted and is discarded.
  - A dn_xfer in the flush cycle completes normally for downstream.
- In EMPTY, dn_data_o holds its last value; it is not a don't-care.
- Payload is passed bit-exact with no width conversion. Beat order is strictly FIFO.

## Timing
- Reset asserted (asynchronous): state EMPTY, dn_valid_o=0, dn_data_o=RESET_DATA, up_ready_o=1, occ_o=0, skid contents cleared.
- Latency: 1 cycle. A beat accepted at edge N is presented on dn_* after edge N.
- Throughput: 1 beat/cycle while dn_ready_i=1.
- Downstream stall: the stage absorbs exactly one further beat (TWO). up_ready_o falls the cycle after entering TWO and rises the cycle after leaving it.
- While dn_valid_o=1 and dn_ready_i=0, dn_data_o and dn_valid_o are stable.
- dn_ready_i has no combinational path to up_ready_o. up_valid_i has no combinational path to dn_valid_o.
- Flush takes effect at the next edge. If flush_i is held, NOP_DATA is re-injected every cycle (FLUSH_NOP=1) or the stage is held empty (FLUSH_NOP=0).
- Reset mid-stream: all beats are lost immediately. There is no handshake obligation across reset.

## Structure
- Shared package pipe_pkg:
  - state enum (EMPTY/ONE/TWO)
  - RV_NOP constant 32'h00000013, which the IF/ID instance passes as NOP_DATA with DATA_W=64 (pc_plus_4, instruction).
- Single module with no sub-module. The skid is a plain register inside.

## Test plan
- Reset, DATA_W=32: dn_valid_o=0, dn_data_o=RESET_DATA, up_ready_o=1, occ_o=0 during and after rst_n low.
- Streaming: beats 1..8 with dn_ready_i=1 -> dn outputs 1..8 one cycle later, one per cycle, occ_o=1 throughout.
- Backpressure: dn_ready_i=0 from beat 3 -> beats 3 and 4 held (occ_o=2, up_ready_o=0 next cycle, dn_data_o=3 stable). Release -> 3, 4, 5 delivered in order with no loss or duplication.
- Flush in TWO, FLUSH_NOP=1, NOP_DATA=32'h00000013:
  - Next cycle dn_valid_o=1, dn_data_o=32'h00000013, occ_o=1, up_ready_o=1.
  - Skid beat is never delivered.
- Flush concurrent with up_xfer of 0xA5, FLUSH_NOP=0: next cycle occ_o=0, dn_valid_o=0, dn_data_o=NOP_DATA, and 0xA5 is never presented.
- Random valid/ready/flush against a reference queue model (10k cycles): order and contents match, and stability holds under backpressure.
